// File: rtl/truth_table_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : truth_table_sweeper                                        |
// | Description : Walks every input minterm m = 0..2**N_IN-1 through an      |
// |               external combinational function, captures its output s_in |
// |               into a truth table, and compares that table against an    |
// |               expected table latched when the sweep starts. Reports      |
// |               match, mismatch count and the lowest failing minterm.      |
// | Ports       : clk, reset (async, active-high), start, expected[TW],      |
// |               s_in  -> stim[N_IN], busy, done (1-cycle pulse),           |
// |               table_out[TW], match, err_count[N_IN+1], first_err[N_IN]   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 s_in,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 match,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err
);

    localparam int TW = 2**N_IN;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_hold = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [3:0]    c_settle = 4'(SETTLE);
    // m is one bit wider than a minterm so the last vector is recognised
    // without the counter ever wrapping back to zero.
    localparam logic [N_IN:0] c_last   = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0] c_one    = {{N_IN{1'b0}}, 1'b1};

    logic [1:0]      r_state,   w_state_nx;
    logic [N_IN:0]   r_m,       w_m_nx;
    logic [3:0]      r_hold,    w_hold_nx;
    logic [TW-1:0]   r_exp,     w_exp_nx;
    logic [N_IN-1:0] r_stim,    w_stim_nx;
    logic            r_busy,    w_busy_nx;
    logic            r_done,    w_done_nx;
    logic [TW-1:0]   r_table,   w_table_nx;
    logic            r_match,   w_match_nx;
    logic [N_IN:0]   r_err,     w_err_nx;
    logic [N_IN-1:0] r_first,   w_first_nx;

    logic [N_IN-1:0] w_idx;
    logic            w_miss;

    assign w_idx  = r_m[N_IN-1:0];
    assign w_miss = s_in ^ r_exp[w_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_m     <= '0;
            r_hold  <= '0;
            r_exp   <= '0;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
            r_match <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
        end else begin
            r_state <= w_state_nx;
            r_m     <= w_m_nx;
            r_hold  <= w_hold_nx;
            r_exp   <= w_exp_nx;
            r_stim  <= w_stim_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_table <= w_table_nx;
            r_match <= w_match_nx;
            r_err   <= w_err_nx;
            r_first <= w_first_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_m_nx     = r_m;
        w_hold_nx  = r_hold;
        w_exp_nx   = r_exp;
        w_stim_nx  = r_stim;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_table_nx = r_table;
        w_match_nx = r_match;
        w_err_nx   = r_err;
        w_first_nx = r_first;

        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_exp_nx   = expected;
                    w_m_nx     = '0;
                    w_stim_nx  = '0;
                    w_table_nx = '0;
                    w_err_nx   = '0;
                    w_first_nx = '0;
                    w_match_nx = 1'b0;
                    w_hold_nx  = c_settle;
                    w_busy_nx  = 1'b1;
                    w_state_nx = c_st_hold;
                end
            end

            c_st_hold: begin
                if (r_hold != 4'd0) begin
                    w_hold_nx = r_hold - 4'd1;
                end else begin
                    // Final cycle of this vector: capture and score it.
                    w_table_nx[w_idx] = s_in;
                    if (w_miss) begin
                        w_err_nx = r_err + c_one;
                        if (r_err == '0) begin
                            w_first_nx = w_idx;
                        end
                    end
                    if (r_m == c_last) begin
                        // Include this last vector's outcome in match.
                        w_match_nx = (r_err == '0) && !w_miss;
                        w_done_nx  = 1'b1;
                        w_stim_nx  = '0;
                        w_state_nx = c_st_done;
                    end else begin
                        w_m_nx     = r_m + c_one;
                        w_stim_nx  = w_m_nx[N_IN-1:0];
                        w_hold_nx  = c_settle;
                    end
                end
            end

            c_st_done: begin
                // start is deliberately not looked at here.
                w_busy_nx  = 1'b0;
                w_state_nx = c_st_idle;
            end

            default: begin
                w_busy_nx  = 1'b0;
                w_state_nx = c_st_idle;
            end
        endcase
    end

    assign stim      = r_stim;
    assign busy      = r_busy;
    assign done      = r_done;
    assign table_out = r_table;
    assign match     = r_match;
    assign err_count = r_err;
    assign first_err = r_first;

endmodule
`default_nettype wire
